serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
// Bit-serial N-bit adder sequencer built around one full_adder gate-level cell.
// The block latches two operands on a start request and feeds the cell one bit
// pair per clock, LSB first, with the carry held in a flop between cycles.
// It assembles the sum in a shift register and reports completion with a
// one-cycle done pulse.
// It lets the datapath trade area for latency wherever a wide adder is not
// justified.
//
// PARAMETERS
// N  8  operand/sum width in bits; legal range N >= 1
//
// PORTS
// clk       in   1  single clock; all state updates on posedge
// reset     in   1  synchronous, active-high reset
// start     in   1  request a new addition; sampled only when busy=0
// a         in   N  operand A; latched in the cycle start is accepted
// b         in   N  operand B; latched in the cycle start is accepted
// cin       in   1  carry-in; latched with operands as initial carry
// busy      out  1  high while an addition is in progress (RUN state)
// done      out  1  one-cycle pulse: sum/cout/overflow valid from this cycle
// sum       out  N  result; held stable from done until the next accepted start
// cout      out  1  carry out of bit N-1
// overflow  out  1  signed overflow = carry into bit N-1 XOR carry out of bit N-1
//
// BEHAVIOUR
// - Reset (any state, including mid-RUN):
//   - state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
//   - Bit counter, carry flop and operand shift registers are cleared.
// - FSM states:
//   - IDLE -> RUN on start=1.
//   - RUN -> RUN while cnt < N-1.
//   - RUN -> DONE when cnt == N-1.
//   - DONE -> RUN if start=1; otherwise DONE -> IDLE.
// - Start acceptance: start is accepted in IDLE or DONE.
//   - Load A/B shift registers from a/b, carry flop from cin, cnt=0.
// - RUN, cycle k (k = 0..N-1):
//   - Cell inputs are A_sr[0], B_sr[0] and the carry flop.
//   - Cell s shifts into sum_sr at the MSB end (sum_sr >> 1 | s << N-1).
//   - Cell cout loads the carry flop; A_sr and B_sr shift right by one.
//   - At k = N-1, capture the carry flop value as carry-into-MSB.
// - DONE entry:
//   - sum <= sum_sr, cout <= final carry, overflow <= cin_msb ^ final carry.
//   - done=1 for exactly this one cycle; busy=0.
// - Latency: start accepted at edge t -> done high in the cycle after edge t+N.
//   - That is N+1 cycles start-to-done, throughput 1 result per N+1 cycles.
// - start while busy=1 is ignored (no re-latch, no abort). Operands may change
//   freely after acceptance.
// - start in the DONE cycle is accepted (back-to-back).
//   - Outputs stay at the previous result until the next DONE.
// - The sum/cout/overflow registers update only on DONE entry and are never
//   partially visible.
// - N=1: RUN lasts one cycle; overflow = cin ^ cout.
//
// TESTING (N=8 unless noted)
// 1. a=0x5A, b=0x3C, cin=0, start 1 cycle -> busy for 8 cycles, done in the
//    9th cycle after start; sum=0x96, cout=0, overflow=1.
// 2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
//    a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
//    a=0x00, b=0x00, cin=1 -> sum=0x01.
// 3. Hold start=1 continuously with a=0x10, b=0x20, then change operands at cycle 3
//    -> first result 0x30; new operands accepted only in the DONE cycle
//    (back-to-back, done spacing = 9 cycles).
// 4. Assert reset at RUN cycle 4 of a=0xAA+0x55 -> next cycle: busy=0, done=0,
//    sum=0, cout=0.
//    A fresh start then yields the correct result 0xFF, cout=0.
// 5. Randomised 1000 starts with random idle gaps, N=8 and N=1 builds
//    -> every sum/cout/overflow matches a reference {cout,sum} = a+b+cin.
//    done is always one cycle wide and sum is stable between dones.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, carry kept in a flop.
// Operands are latched on start, the result appears with a one-cycle done pulse
// and is held until the next result replaces it in a single update.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);
    // A counter width of at least one bit keeps the N=1 build legal.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   sum_sr;
    logic [N-1:0]   sum_nx;
    logic           carry;
    logic           fa_s;
    logic           fa_co;
    logic           accept;
    logic           last_bit;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next state, start acceptance and status outputs.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        last_bit = (cnt == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // New sum bit enters at the MSB end while earlier bits move toward the LSB.
    always_comb begin
        sum_nx      = sum_sr >> 1;
        sum_nx[N-1] = fa_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Operand shifting, carry flop and result capture on the final bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            a_sr     <= a;
            b_sr     <= b;
            sum_sr   <= '0;
            carry    <= cin;
        end else if (state == RUN) begin
            cnt    <= cnt + CW'(1);
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_nx;
            carry  <= fa_co;
            // On the last bit the carry flop holds the carry into the MSB.
            if (last_bit) begin
                sum      <= sum_nx;
                cout     <= fa_co;
                overflow <= carry ^ fa_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios on an N=8
// instance, then randomised traffic on both N=8 and N=1 instances against a
// plain-arithmetic reference.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8, ov8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1, ov1;
    logic [0:0] sum1;

    int tests = 0;
    int fails = 0;
    logic [7:0] last8;
    logic [0:0] last1;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
    );

    serial_adder_ctrl #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ov1)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one N=8 addition and wait (bounded) for done; lat counts cycles
    // from the accepting edge up to and including the done cycle.
    task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 50) begin
            step();
            lat++;
        end
        s = sum8; co = cout8; ov = ov8;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        tests++;
        if ({busy8, done8, sum8, cout8, ov8} !== 12'h000) begin
            fails++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ov=%b, want all 0",
                     busy8, done8, sum8, cout8, ov8);
        end
        tests++;
        if ({busy1, done1, sum1, cout1, ov1} !== 5'b0) begin
            fails++;
            $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b ov=%b, want all 0",
                     busy1, done1, sum1, cout1, ov1);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                fails++;
                $display("FAIL basic_busy cycle %0d: busy=%b done=%b, want busy=1 done=0",
                         i, busy8, done8);
            end
            step();
        end
        tests++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== 8'h96 || cout8 !== 1'b0 || ov8 !== 1'b1) begin
            fails++;
            $display("FAIL basic_result: done=%b busy=%b sum=%h cout=%b ov=%b, want 1 0 96 0 1",
                     done8, busy8, sum8, cout8, ov8);
        end
        step();
        tests++;
        if (done8 !== 1'b0 || sum8 !== 8'h96) begin
            fails++;
            $display("FAIL basic_pulse: done=%b sum=%h, want done=0 sum=96", done8, sum8);
        end
    endtask

    task automatic test_carry();
        logic [7:0] s; logic co, ov; int lat;
        add8(8'hFF, 8'h01, 1'b0, s, co, ov, lat);
        tests++;
        if ({co, s, ov} !== {1'b1, 8'h00, 1'b0} || lat !== 9) begin
            fails++;
            $display("FAIL carry_ff01: sum=%h cout=%b ov=%b lat=%0d, want 00 1 0 9", s, co, ov, lat);
        end
        step();
        add8(8'h80, 8'h80, 1'b0, s, co, ov, lat);
        tests++;
        if ({co, s, ov} !== {1'b1, 8'h00, 1'b1} || lat !== 9) begin
            fails++;
            $display("FAIL carry_8080: sum=%h cout=%b ov=%b lat=%0d, want 00 1 1 9", s, co, ov, lat);
        end
        step();
        add8(8'h00, 8'h00, 1'b1, s, co, ov, lat);
        tests++;
        if ({co, s, ov} !== {1'b0, 8'h01, 1'b0} || lat !== 9) begin
            fails++;
            $display("FAIL carry_cin: sum=%h cout=%b ov=%b lat=%0d, want 01 0 0 9", s, co, ov, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        step();
        n = 1;
        while (!done8 && n < 50) begin
            if (n == 3) begin a8 = 8'h01; b8 = 8'h02; end
            step();
            n++;
        end
        tests++;
        if (n !== 9 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: sum=%h cout=%b lat=%0d, want 30 0 9", sum8, cout8, n);
        end
        // start is still high in this DONE cycle, so the new operands go in now.
        step();
        n = 1;
        while (!done8 && n < 50) begin
            tests++;
            if (sum8 !== 8'h30) begin
                fails++;
                $display("FAIL b2b_hold: sum=%h, want 30 until next done", sum8);
            end
            step();
            n++;
        end
        start8 = 1'b0;
        tests++;
        if (n !== 9 || sum8 !== 8'h03) begin
            fails++;
            $display("FAIL b2b_second: sum=%h spacing=%0d, want 03 9", sum8, n);
        end
        step();
    endtask

    task automatic test_reset_midrun();
        logic [7:0] s; logic co, ov; int lat;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                     busy8, done8, sum8, cout8);
        end
        step();
        add8(8'hAA, 8'h55, 1'b0, s, co, ov, lat);
        tests++;
        if (s !== 8'hFF || co !== 1'b0 || ov !== 1'b0 || lat !== 9) begin
            fails++;
            $display("FAIL midrun_fresh: sum=%h cout=%b ov=%b lat=%0d, want FF 0 0 9", s, co, ov, lat);
        end
        last8 = 8'hFF;
        last1 = 1'b0;
    endtask

    task automatic test_random8();
        logic [7:0] ea, eb, es; logic ec, eco, eov; logic [8:0] tot;
        int n, gap; bit b2b;
        b2b = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
            tot = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
            es = tot[7:0]; eco = tot[8];
            eov = (ea[7] == eb[7]) && (es[7] != ea[7]);
            a8 = ea; b8 = eb; cin8 = ec; start8 = 1'b1;
            step();
            n = 1;
            while (!done8 && n < 50) begin
                tests++;
                if (sum8 !== last8) begin
                    fails++;
                    $display("FAIL rand8_stable #%0d: sum=%h, want %h", k, sum8, last8);
                end
                // Noise on the inputs while busy must not disturb the sum.
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                start8 = 1'($urandom);
                step();
                n++;
            end
            start8 = 1'b0;
            tests++;
            if (n !== 9 || sum8 !== es || cout8 !== eco || ov8 !== eov) begin
                fails++;
                $display("FAIL rand8 #%0d %h+%h+%b: sum=%h cout=%b ov=%b lat=%0d, want %h %b %b 9",
                         k, ea, eb, ec, sum8, cout8, ov8, n, es, eco, eov);
            end
            last8 = es;
            b2b = ($urandom_range(0, 3) == 0);
            if (!b2b) begin
                gap = $urandom_range(1, 4);
                for (int g = 0; g < gap; g++) begin
                    step();
                    tests++;
                    if (done8 !== 1'b0 || sum8 !== last8) begin
                        fails++;
                        $display("FAIL rand8_idle #%0d: done=%b sum=%h, want 0 %h", k, done8, sum8, last8);
                    end
                end
            end
        end
        step();
    endtask

    task automatic test_random1();
        logic ea, eb, ec, es, eco, eov; logic [1:0] tot;
        int n, gap;
        for (int k = 0; k < 1000; k++) begin
            ea = 1'($urandom); eb = 1'($urandom); ec = 1'($urandom);
            tot = {1'b0, ea} + {1'b0, eb} + {1'b0, ec};
            es = tot[0]; eco = tot[1];
            eov = ec ^ eco;
            a1 = ea; b1 = eb; cin1 = ec; start1 = 1'b1;
            step();
            n = 1;
            while (!done1 && n < 50) begin
                a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
                start1 = 1'($urandom);
                step();
                n++;
            end
            start1 = 1'b0;
            tests++;
            if (n !== 2 || sum1 !== es || cout1 !== eco || ov1 !== eov) begin
                fails++;
                $display("FAIL rand1 #%0d %b+%b+%b: sum=%b cout=%b ov=%b lat=%0d, want %b %b %b 2",
                         k, ea, eb, ec, sum1, cout1, ov1, n, es, eco, eov);
            end
            last1 = es;
            if ($urandom_range(0, 3) != 0) begin
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    step();
                    tests++;
                    if (done1 !== 1'b0 || sum1 !== last1) begin
                        fails++;
                        $display("FAIL rand1_idle #%0d: done=%b sum=%b, want 0 %b", k, done1, sum1, last1);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_midrun();
        test_random8();
        test_random1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
